// File: rtl/serial_link_pkg.sv
// Shared definitions for the one-wire serial link (transmit and receive ends).
// Holds the framing constants, the receiver state type and the default word width.
package serial_link_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      STOP
   } state_t;

   localparam logic LINE_IDLE = 1'b1;
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

   localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/sipo_shift_reg.sv
// Serial-in/parallel-out register. Each enabled shift moves a bit in at the MSB,
// so the first bit shifted in ends up in bit 0 after WIDTH shifts.
module sipo_shift_reg #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             shift_en,
   input  logic             din,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else if (shift_en) begin
         q <= {din, q[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/serial_frame_receiver.sv
// Receive end of the one-wire serial link. It samples the line on each bit strobe,
// checks start/stop framing and holds finished words behind a valid/ready handshake.
module serial_frame_receiver
   import serial_link_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             bit_en,
   input  logic             sin,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic             frame_err,
   output logic             overrun,
   output logic             busy
);

   localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   state_t           state;
   state_t           next_state;
   logic [CW-1:0]    bit_cnt;
   logic [WIDTH-1:0] shift_q;
   logic             start_seen;
   logic             shift_en;
   logic             stop_strobe;
   logic             stop_ok;
   logic             load_word;

   assign start_seen  = bit_en && (state == IDLE) && (sin == START_BIT);
   assign shift_en    = bit_en && (state == DATA);
   assign stop_strobe = bit_en && (state == STOP);
   assign stop_ok     = stop_strobe && (sin == STOP_BIT);
   // A held word may be replaced in the same cycle the consumer takes it.
   assign load_word   = stop_ok && (!dout_valid || dout_ready);
   assign busy        = (state != IDLE);

   sipo_shift_reg #(.WIDTH(WIDTH)) u_shift (
      .clk      (clk),
      .rst_n    (rst_n),
      .shift_en (shift_en),
      .din      (sin),
      .q        (shift_q)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: if (start_seen) next_state = DATA;
         DATA: if (shift_en && (bit_cnt == LAST_BIT)) next_state = STOP;
         STOP: if (bit_en) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Counter, output word register, handshake and the one-clock status pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt    <= '0;
         dout       <= '0;
         dout_valid <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         frame_err <= stop_strobe && (sin != STOP_BIT);
         overrun   <= stop_ok && dout_valid && !dout_ready;

         if (start_seen) begin
            bit_cnt <= '0;
         end else if (shift_en) begin
            bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + CW'(1);
         end

         if (load_word) begin
            dout       <= shift_q;
            dout_valid <= 1'b1;
         end else if (dout_valid && dout_ready) begin
            dout_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Directed bench for serial_frame_receiver: a table of frames with hand-computed
// results plus explicit sequences for reset mid-frame and back-to-back frames.
module tb_serial_frame_receiver;

   localparam int WIDTH = 8;

   typedef struct {
      logic [7:0] data;
      logic       stop_bit;
      logic       ready_at_stop;
      logic       pop_after;
      logic [7:0] exp_dout;
      logic       exp_valid;
      logic       exp_overrun;
      logic       exp_frame_err;
   } vec_t;

   logic             clk;
   logic             rst_n;
   logic             bit_en;
   logic             sin;
   logic [WIDTH-1:0] dout;
   logic             dout_valid;
   logic             dout_ready;
   logic             frame_err;
   logic             overrun;
   logic             busy;

   int checks;
   int errors;
   int ferr_count;
   int ovr_count;

   vec_t vecs[6];

   serial_frame_receiver #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bit_en     (bit_en),
      .sin        (sin),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .frame_err  (frame_err),
      .overrun    (overrun),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counts high cycles of each pulse so stretched or spurious pulses show up.
   always @(negedge clk) begin
      if (frame_err) ferr_count++;
      if (overrun) ovr_count++;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [15:0] actual,
                              input logic [15:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic sendBit(input logic b, input logic rdy, input int gap);
      sin        = b;
      bit_en     = 1'b1;
      dout_ready = rdy;
      @(negedge clk);
      bit_en     = 1'b0;
      dout_ready = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   // Leaves the caller at the falling edge just after the stop-bit strobe.
   task automatic sendFrame(input logic [7:0] data, input logic stop_bit,
                            input logic rdy_data, input logic rdy_stop, input int gap);
      sendBit(1'b0, rdy_data, gap);
      for (int i = 0; i < WIDTH; i++) sendBit(data[i], rdy_data, gap);
      sendBit(stop_bit, rdy_stop, 0);
   endtask

   task automatic popWord(input string name);
      dout_ready = 1'b1;
      @(negedge clk);
      dout_ready = 1'b0;
      checkOutput(name, 16'(dout_valid), 16'h0);
   endtask

   task automatic applyStimulus(input int idx);
      vec_t v;
      v = vecs[idx];
      sendFrame(v.data, v.stop_bit, 1'b0, v.ready_at_stop, 3);
      sin = 1'b1;
      checkOutput($sformatf("v%0d dout", idx), 16'(dout), 16'(v.exp_dout));
      checkOutput($sformatf("v%0d valid", idx), 16'(dout_valid), 16'(v.exp_valid));
      checkOutput($sformatf("v%0d overrun", idx), 16'(overrun), 16'(v.exp_overrun));
      checkOutput($sformatf("v%0d frame_err", idx), 16'(frame_err), 16'(v.exp_frame_err));
      checkOutput($sformatf("v%0d busy", idx), 16'(busy), 16'h0);
      @(negedge clk);
      checkOutput($sformatf("v%0d overrun clear", idx), 16'(overrun), 16'h0);
      checkOutput($sformatf("v%0d frame_err clear", idx), 16'(frame_err), 16'h0);
      checkOutput($sformatf("v%0d dout hold", idx), 16'(dout), 16'(v.exp_dout));
      if (v.pop_after) popWord($sformatf("v%0d pop", idx));
      repeat (2) @(negedge clk);
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      ferr_count = 0;
      ovr_count  = 0;
      rst_n      = 1'b0;
      sin        = 1'b1;
      bit_en     = 1'b0;
      dout_ready = 1'b0;

      //          data    stop  rdy   pop   exp_dout valid ovr   ferr
      vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 8'hA5,   1'b1, 1'b0, 1'b0};
      vecs[1] = '{8'h3C, 1'b1, 1'b0, 1'b1, 8'hA5,   1'b1, 1'b1, 1'b0};
      vecs[2] = '{8'h11, 1'b1, 1'b0, 1'b0, 8'h11,   1'b1, 1'b0, 1'b0};
      vecs[3] = '{8'h3C, 1'b1, 1'b1, 1'b0, 8'h3C,   1'b1, 1'b0, 1'b0};
      vecs[4] = '{8'hFF, 1'b0, 1'b0, 1'b0, 8'h3C,   1'b1, 1'b0, 1'b1};
      vecs[5] = '{8'h01, 1'b1, 1'b1, 1'b1, 8'h01,   1'b1, 1'b0, 1'b0};

      repeat (2) @(negedge clk);
      checkOutput("reset dout", 16'(dout), 16'h0);
      checkOutput("reset valid", 16'(dout_valid), 16'h0);
      checkOutput("reset busy", 16'(busy), 16'h0);
      checkOutput("reset frame_err", 16'(frame_err), 16'h0);
      checkOutput("reset overrun", 16'(overrun), 16'h0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      $display("[TB] table-driven frames");
      for (int i = 0; i < 6; i++) applyStimulus(i);

      $display("[TB] reset in the middle of a frame");
      sendBit(1'b0, 1'b0, 3);
      sendBit(1'b0, 1'b0, 3);
      sendBit(1'b1, 1'b0, 3);
      sendBit(1'b0, 1'b0, 3);
      sendBit(1'b1, 1'b0, 3);
      checkOutput("midframe busy", 16'(busy), 16'h1);
      checkOutput("midframe dout", 16'(dout), 16'h01);
      rst_n = 1'b0;
      #1;
      checkOutput("async reset dout", 16'(dout), 16'h0);
      checkOutput("async reset busy", 16'(busy), 16'h0);
      @(negedge clk);
      rst_n = 1'b1;
      sin   = 1'b1;
      repeat (2) @(negedge clk);
      sendFrame(8'h81, 1'b1, 1'b0, 1'b0, 3);
      sin = 1'b1;
      checkOutput("after reset dout", 16'(dout), 16'h81);
      checkOutput("after reset valid", 16'(dout_valid), 16'h1);
      @(negedge clk);
      popWord("after reset pop");
      checkOutput("frame_err pulse cycles", 16'(ferr_count), 16'd1);
      checkOutput("overrun pulse cycles", 16'(ovr_count), 16'd1);

      $display("[TB] back-to-back frames with bit_en held high");
      sendFrame(8'h00, 1'b1, 1'b1, 1'b1, 0);
      checkOutput("b2b first dout", 16'(dout), 16'h00);
      checkOutput("b2b first valid", 16'(dout_valid), 16'h1);
      sendFrame(8'hFF, 1'b1, 1'b1, 1'b1, 0);
      sin = 1'b1;
      checkOutput("b2b second dout", 16'(dout), 16'hFF);
      checkOutput("b2b second valid", 16'(dout_valid), 16'h1);
      checkOutput("b2b busy", 16'(busy), 16'h0);
      repeat (2) @(negedge clk);
      checkOutput("b2b frame_err cycles", 16'(ferr_count), 16'd1);
      checkOutput("b2b overrun cycles", 16'(ovr_count), 16'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
